// File: rtl/lanzones_rdport_arb.sv
// Read-port arbiter for the lanzones core: shares one memory read port between
// instruction fetch (F) and data load (D), one outstanding transaction at a time.
module lanzones_rdport_arb #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned DBURST  = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          FReq,
    input  logic [AW-1:0] FAddr,
    output logic          FRdy,
    output logic          FVld,
    input  logic          DReq,
    input  logic [AW-1:0] DAddr,
    output logic          DRdy,
    output logic          DVld,
    output logic [DW-1:0] RspData,
    output logic          RspErr,
    output logic          MReq,
    output logic [AW-1:0] MAddr,
    input  logic          MAck,
    input  logic          MVld,
    input  logic [DW-1:0] MData,
    output logic          Busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic [3:0]  DB_LIMIT = 4'(DBURST);
    localparam bit          TO_EN    = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST  = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [3:0]    dcnt_q, dcnt_d;
    logic [15:0]   tcnt_q, tcnt_d;
    logic          owner_d_q, owner_d_d;   // 1: transaction belongs to D
    logic [AW-1:0] maddr_q, maddr_d;
    logic          mreq_q, mreq_d;
    logic          fvld_q, fvld_d;
    logic          dvld_q, dvld_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          frdy_s, drdy_s;

    // Next-state, grant and response logic
    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        tcnt_d     = tcnt_q;
        owner_d_d  = owner_d_q;
        maddr_d    = maddr_q;
        mreq_d     = mreq_q;
        fvld_d     = 1'b0;
        dvld_d     = 1'b0;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        frdy_s     = 1'b0;
        drdy_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // D wins unless F has been passed over DBURST times in a row
                if (DReq && !(FReq && (dcnt_q == DB_LIMIT))) begin
                    drdy_s    = 1'b1;
                    maddr_d   = DAddr;
                    owner_d_d = 1'b1;
                    mreq_d    = 1'b1;
                    state_d   = ST_ISSUE;
                    if (FReq) begin
                        dcnt_d = (dcnt_q == DB_LIMIT) ? dcnt_q : dcnt_q + 4'd1;
                    end else begin
                        dcnt_d = 4'd0;
                    end
                end else if (FReq) begin
                    frdy_s    = 1'b1;
                    maddr_d   = FAddr;
                    owner_d_d = 1'b0;
                    mreq_d    = 1'b1;
                    dcnt_d    = 4'd0;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (MAck) begin
                    mreq_d  = 1'b0;
                    tcnt_d  = 16'd0;
                    state_d = ST_WAIT;
                end else begin
                    mreq_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (MVld) begin
                    fvld_d     = !owner_d_q;
                    dvld_d     = owner_d_q;
                    rsp_data_d = MData;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_IDLE;
                end else if (TO_EN && (tcnt_q == TO_LAST)) begin
                    fvld_d     = !owner_d_q;
                    dvld_d     = owner_d_q;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            default: begin
                mreq_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            dcnt_q     <= 4'd0;
            tcnt_q     <= 16'd0;
            owner_d_q  <= 1'b0;
            maddr_q    <= '0;
            mreq_q     <= 1'b0;
            fvld_q     <= 1'b0;
            dvld_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            tcnt_q     <= tcnt_d;
            owner_d_q  <= owner_d_d;
            maddr_q    <= maddr_d;
            mreq_q     <= mreq_d;
            fvld_q     <= fvld_d;
            dvld_q     <= dvld_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign FRdy    = frdy_s;
    assign DRdy    = drdy_s;
    assign FVld    = fvld_q;
    assign DVld    = dvld_q;
    assign RspData = rsp_data_q;
    assign RspErr  = rsp_err_q;
    assign MReq    = mreq_q;
    assign MAddr   = maddr_q;
    assign Busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lanzones_rdport_arb.sv
// Directed bench for lanzones_rdport_arb: a per-cycle vector table plus
// hand-written sequences for burst fairness, slow accept, timeout and reset.
module tb_lanzones_rdport_arb;

    logic        clk;
    logic        rstn;
    logic        FReq, DReq, MAck, MVld;
    logic [31:0] FAddr, DAddr, MData;
    logic        FRdy, FVld, DRdy, DVld, RspErr, MReq, Busy;
    logic [31:0] RspData, MAddr;

    int n_tests = 0;
    int n_fail  = 0;

    lanzones_rdport_arb dut (
        .clk(clk), .rstn(rstn),
        .FReq(FReq), .FAddr(FAddr), .FRdy(FRdy), .FVld(FVld),
        .DReq(DReq), .DAddr(DAddr), .DRdy(DRdy), .DVld(DVld),
        .RspData(RspData), .RspErr(RspErr),
        .MReq(MReq), .MAddr(MAddr), .MAck(MAck), .MVld(MVld), .MData(MData),
        .Busy(Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {FRdy, DRdy, FVld, DVld, MReq, Busy, RspErr}
    typedef struct {
        logic        freq;
        logic [31:0] faddr;
        logic        dreq;
        logic [31:0] daddr;
        logic        mack;
        logic        mvld;
        logic [31:0] mdata;
        logic [6:0]  flags;
        logic [31:0] maddr;
        logic [31:0] rsp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic fq, logic [31:0] fa, logic dq, logic [31:0] da,
                                logic ma, logic mv, logic [31:0] md,
                                logic [6:0] fl, logic [31:0] exp_ma, logic [31:0] exp_rsp);
        vec_t v;
        v.freq = fq; v.faddr = fa; v.dreq = dq; v.daddr = da;
        v.mack = ma; v.mvld = mv; v.mdata = md;
        v.flags = fl; v.maddr = exp_ma; v.rsp = exp_rsp;
        return v;
    endfunction

    task automatic check(string name, logic [127:0] got, logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] cur_flags();
        return {FRdy, DRdy, FVld, DVld, MReq, Busy, RspErr};
    endfunction

    // Apply inputs on the falling edge and let outputs settle before sampling
    task automatic drive(logic fq, logic [31:0] fa, logic dq, logic [31:0] da,
                         logic ma, logic mv, logic [31:0] md);
        @(negedge clk);
        FReq = fq; FAddr = fa; DReq = dq; DAddr = da;
        MAck = ma; MVld = mv; MData = md;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        FReq = 1'b0; DReq = 1'b0; MAck = 1'b0; MVld = 1'b0;
        FAddr = 32'h0; DAddr = 32'h0; MData = 32'h0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [9:0] exp_own;
        int ng;
        int nv;
        rstn = 1'b0;
        FReq = 1'b0; DReq = 1'b0; MAck = 1'b0; MVld = 1'b0;
        FAddr = 32'h0; DAddr = 32'h0; MData = 32'h0;
        #1;
        check("reset_state", {cur_flags(), MAddr, RspData}, {7'b0, 32'h0, 32'h0});
        do_reset();

        // Vector table: single F, spurious MVld, D with slow MAck, simultaneous requests
        vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0, 0,            7'b1000000, 32'h00, 32'h0));
        vecs.push_back(mk(0, 0,      0, 0, 1, 0, 0,            7'b0000110, 32'h10, 32'h0));
        vecs.push_back(mk(0, 0,      0, 0, 0, 1, 32'hCAFEBABE, 7'b0000010, 32'h10, 32'h0));
        vecs.push_back(mk(0, 0,      0, 0, 0, 0, 0,            7'b0010000, 32'h10, 32'hCAFEBABE));
        vecs.push_back(mk(0, 0,      0, 0, 0, 1, 32'h12345678, 7'b0000000, 32'h10, 32'hCAFEBABE));
        vecs.push_back(mk(0, 0,      0, 0, 0, 0, 0,            7'b0000000, 32'h10, 32'hCAFEBABE));
        vecs.push_back(mk(0, 0,      1, 32'h20, 0, 0, 0,       7'b0100000, 32'h10, 32'hCAFEBABE));
        vecs.push_back(mk(0, 0,      0, 0, 0, 0, 0,            7'b0000110, 32'h20, 32'hCAFEBABE));
        vecs.push_back(mk(0, 0,      0, 0, 1, 0, 0,            7'b0000110, 32'h20, 32'hCAFEBABE));
        vecs.push_back(mk(0, 0,      0, 0, 0, 1, 32'h55,       7'b0000010, 32'h20, 32'hCAFEBABE));
        vecs.push_back(mk(1, 32'h30, 1, 32'h40, 0, 0, 0,       7'b0101000, 32'h20, 32'h55));
        vecs.push_back(mk(1, 32'h30, 0, 0, 1, 0, 0,            7'b0000110, 32'h40, 32'h55));
        vecs.push_back(mk(1, 32'h30, 0, 0, 0, 1, 32'h77,       7'b0000010, 32'h40, 32'h55));
        vecs.push_back(mk(1, 32'h30, 0, 0, 0, 0, 0,            7'b1001000, 32'h40, 32'h77));
        vecs.push_back(mk(0, 0,      0, 0, 1, 0, 0,            7'b0000110, 32'h30, 32'h77));
        vecs.push_back(mk(0, 0,      0, 0, 0, 1, 32'h99,       7'b0000010, 32'h30, 32'h77));
        vecs.push_back(mk(0, 0,      0, 0, 0, 0, 0,            7'b0010000, 32'h30, 32'h99));
        vecs.push_back(mk(1, 32'h80, 0, 0, 0, 0, 0,            7'b1000000, 32'h30, 32'h99));
        vecs.push_back(mk(0, 0,      0, 0, 0, 1, 32'hDEAD,     7'b0000110, 32'h80, 32'h99));
        vecs.push_back(mk(0, 0,      0, 0, 1, 0, 0,            7'b0000110, 32'h80, 32'h99));
        vecs.push_back(mk(0, 0,      0, 0, 0, 0, 0,            7'b0000010, 32'h80, 32'h99));
        vecs.push_back(mk(0, 0,      0, 0, 0, 1, 32'hBEEF,     7'b0000010, 32'h80, 32'h99));
        vecs.push_back(mk(0, 0,      0, 0, 0, 0, 0,            7'b0010000, 32'h80, 32'hBEEF));

        foreach (vecs[i]) begin
            drive(vecs[i].freq, vecs[i].faddr, vecs[i].dreq, vecs[i].daddr,
                  vecs[i].mack, vecs[i].mvld, vecs[i].mdata);
            check($sformatf("vec%0d", i), {cur_flags(), MAddr, RspData},
                  {vecs[i].flags, vecs[i].maddr, vecs[i].rsp});
        end

        // Burst fairness: both requesters held, zero-wait memory
        do_reset();
        exp_own = 10'b0111101111;   // bit i = 1 -> i-th grant goes to D
        ng = 0;
        nv = 0;
        @(negedge clk);
        FReq = 1'b1; FAddr = 32'h100; DReq = 1'b1; DAddr = 32'h200;
        MAck = 1'b1; MVld = 1'b1; MData = 32'hD0D0;
        for (int cyc = 0; cyc < 80 && nv < 10; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            if ((FRdy || DRdy) && ng < 10) begin
                check($sformatf("burst_grant%0d", ng), {FRdy, DRdy}, {!exp_own[ng], exp_own[ng]});
                ng++;
            end
            if (FVld || DVld) begin
                check($sformatf("burst_vld%0d", nv), {FVld, DVld}, {!exp_own[nv], exp_own[nv]});
                nv++;
            end
        end
        check("burst_vld_count", nv, 10);
        @(negedge clk);
        FReq = 1'b0; DReq = 1'b0;
        for (int cyc = 0; cyc < 10 && Busy; cyc++) @(negedge clk);
        check("burst_drain", Busy, 1'b0);

        // Slow accept: MAck arrives on the sixth ISSUE cycle
        do_reset();
        drive(0, 0, 1, 32'h300, 0, 0, 0);
        check("slow_grant", {FRdy, DRdy}, 2'b01);
        for (int i = 1; i <= 6; i++) begin
            drive(1, 32'h310, 1, 32'h300, (i == 6), 0, 0);
            check($sformatf("slow_issue%0d", i), {FRdy, DRdy, MReq, Busy, MAddr},
                  {4'b0011, 32'h300});
        end
        drive(0, 0, 0, 0, 0, 1, 32'hABCD);
        check("slow_wait", {MReq, Busy}, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("slow_rsp", {FVld, DVld, RspErr, RspData}, {3'b010, 32'hABCD});

        // Timeout: no MVld, error response 16 cycles after entering WAIT
        do_reset();
        drive(0, 0, 1, 32'h400, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            n_tests++;
            if (DVld || FVld || !Busy) begin
                n_fail++;
                $display("FAIL to_wait%0d: DVld=%0b FVld=%0b Busy=%0b, required 0 0 1",
                         i, DVld, FVld, Busy);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("to_rsp", {FVld, DVld, RspErr, Busy, RspData}, {4'b0110, 32'h0});
        drive(1, 32'h500, 0, 0, 0, 0, 0);
        check("to_next_grant", {FRdy, RspErr}, 2'b11);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h1111);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("to_next_rsp", {FVld, DVld, RspErr, RspData}, {3'b100, 32'h1111});

        // Reset in WAIT: transaction dropped, outputs cleared immediately
        drive(1, 32'h600, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rst_in_wait_busy", {Busy, MAddr}, {1'b1, 32'h600});
        rstn = 1'b0;
        #1;
        check("rst_outputs", {cur_flags(), MAddr, RspData}, {7'b0, 32'h0, 32'h0});
        @(negedge clk);
        rstn = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 32'h5A5A);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rst_stray_mvld", {FVld, DVld, Busy, RspData}, {3'b000, 32'h0});
        drive(1, 32'h700, 0, 0, 0, 0, 0);
        check("rst_next_grant", {FRdy, DRdy}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
